phase_sequencer: RTL and testbench

//  Instruction-cycle controller for the CPU core. Drives the one-hot PHASEX {COMMIT,EXECUTE,DECODE,FETCH}

---
 rtl/cpu_defs.sv | 38 +++
 rtl/wait_timer.sv | 35 +++
 rtl/phase_sequencer.sv | 131 +++++++++++++
 tb/tb_phase_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the CPU core: phase one-hot codes,
// instruction group codes and sequencer state encoding.
package cpu_defs;

  localparam logic [3:0] PH_NONE    = 4'b0000;
  localparam logic [3:0] PH_FETCH   = 4'b0001;
  localparam logic [3:0] PH_DECODE  = 4'b0010;
  localparam logic [3:0] PH_EXECUTE = 4'b0100;
  localparam logic [3:0] PH_COMMIT  = 4'b1000;

  localparam logic [1:0] GRP_SYS  = 2'b00;
  localparam logic [1:0] GRP_LDST = 2'b01;
  localparam logic [1:0] GRP_JMP  = 2'b10;
  localparam logic [1:0] GRP_ALU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_GRANT   = 3'd5
  } seq_state_e;

  function automatic logic [3:0] phase_of(seq_state_e s);
    logic [3:0] ph;
    ph = PH_NONE;
    case (s)
      ST_FETCH:   ph = PH_FETCH;
      ST_DECODE:  ph = PH_DECODE;
      ST_EXECUTE: ph = PH_EXECUTE;
      ST_COMMIT:  ph = PH_COMMIT;
      default:    ph = PH_NONE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating memory wait-state counter; EXPIRED once the
// count reaches WAIT_MAX (never asserted when WAIT_MAX is 0).
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [W-1:0] CMAX = W'(WAIT_MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != CMAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (WAIT_MAX != 0) && (cnt_q == CMAX);

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-cycle controller: F/D/E/C phases, memory wait
// states with timeout abort, bus grant at instruction boundaries.
module phase_sequencer
  import cpu_defs::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       RUN,
  input  logic [1:0] GROUPX,
  input  logic       STX,
  input  logic       MEM_READY,
  input  logic       BUS_REQ,
  input  logic       ERR_CLR,
  output logic [3:0] PHASEX,
  output logic       MEM_REQ,
  output logic       MEM_WE,
  output logic       INSTR_LD,
  output logic       PC_INC,
  output logic       BUS_GNT,
  output logic       HALTED,
  output logic       TIMEOUT
);

  seq_state_e state_q, state_d;
  logic       timeout_q, timeout_d;
  logic       ldst;
  logic       abort;
  logic       expired;
  logic       wt_clr;
  logic       wt_en;

  always_comb begin
    ldst = 1'b0;
    unique case (1'b1)
      (GROUPX == GRP_LDST): ldst = 1'b1;
      (GROUPX == GRP_SYS),
      (GROUPX == GRP_JMP),
      (GROUPX == GRP_ALU):  ldst = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (BUS_REQ)
          state_d = ST_GRANT;
        else if (RUN && !timeout_q)
          state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (MEM_READY)
          state_d = ST_DECODE;
        else if (expired) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end
      end
      ST_DECODE:
        state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (!ldst || MEM_READY)
          state_d = ST_COMMIT;
        else if (expired) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end
      end
      ST_COMMIT: begin
        if (BUS_REQ)
          state_d = ST_GRANT;
        else if (RUN && !timeout_q)
          state_d = ST_FETCH;
        else
          state_d = ST_IDLE;
      end
      ST_GRANT: begin
        if (!BUS_REQ)
          state_d = ST_IDLE;
      end
      default:
        state_d = ST_IDLE;
    endcase
  end

  // an abort in the same cycle as ERR_CLR keeps the flag set
  always_comb begin
    timeout_d = timeout_q;
    if (abort)
      timeout_d = 1'b1;
    else if (ERR_CLR)
      timeout_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ST_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  assign wt_clr = (state_d != state_q);
  assign wt_en  = MEM_REQ && !MEM_READY;

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .clr_i     (wt_clr),
    .en_i      (wt_en),
    .expired_o (expired)
  );

  assign PHASEX   = phase_of(state_q);
  assign MEM_REQ  = (state_q == ST_FETCH) ||
                    ((state_q == ST_EXECUTE) && ldst);
  assign MEM_WE   = (state_q == ST_EXECUTE) && ldst && STX;
  assign INSTR_LD = (state_q == ST_FETCH) && MEM_READY;
  assign PC_INC   = (state_q == ST_COMMIT);
  assign BUS_GNT  = (state_q == ST_GRANT);
  assign HALTED   = (state_q == ST_IDLE);
  assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: vector table,
// directed corner sequences and a randomized reference model.
module tb_phase_sequencer;

  localparam int WM = 15;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       RUN = 1'b0;
  logic [1:0] GROUPX = 2'b00;
  logic       STX = 1'b0;
  logic       MEM_READY = 1'b0;
  logic       BUS_REQ = 1'b0;
  logic       ERR_CLR = 1'b0;
  logic [3:0] PHASEX;
  logic       MEM_REQ, MEM_WE, INSTR_LD, PC_INC;
  logic       BUS_GNT, HALTED, TIMEOUT;

  int n_cmp = 0;
  int n_err = 0;

  phase_sequencer #(.WAIT_MAX(WM)) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .RUN       (RUN),
    .GROUPX    (GROUPX),
    .STX       (STX),
    .MEM_READY (MEM_READY),
    .BUS_REQ   (BUS_REQ),
    .ERR_CLR   (ERR_CLR),
    .PHASEX    (PHASEX),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .INSTR_LD  (INSTR_LD),
    .PC_INC    (PC_INC),
    .BUS_GNT   (BUS_GNT),
    .HALTED    (HALTED),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       run;
    logic [1:0] grp;
    logic       stx, rdy, breq, eclr;
    logic [3:0] ph;
    logic       req, we, ild, pci, gnt, hlt, to;
  } vec_t;

  function automatic vec_t mk(
    input logic run, input logic [1:0] grp,
    input logic stx, input logic rdy,
    input logic breq, input logic eclr,
    input logic [3:0] ph, input logic req,
    input logic we, input logic ild,
    input logic pci, input logic gnt,
    input logic hlt, input logic to);
    vec_t v;
    v.run = run; v.grp = grp; v.stx = stx;
    v.rdy = rdy; v.breq = breq; v.eclr = eclr;
    v.ph = ph; v.req = req; v.we = we;
    v.ild = ild; v.pci = pci; v.gnt = gnt;
    v.hlt = hlt; v.to = to;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {PHASEX, MEM_REQ, MEM_WE, INSTR_LD,
            PC_INC, BUS_GNT, HALTED, TIMEOUT};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic run, input logic [1:0] grp,
                       input logic stx, input logic rdy,
                       input logic breq, input logic eclr);
    RUN = run; GROUPX = grp; STX = stx;
    MEM_READY = rdy; BUS_REQ = breq; ERR_CLR = eclr;
  endtask

  task automatic go_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    RESETN = 1'b0;
    #3;
    go_edge();
    RESETN = 1'b1;
  endtask

  // Reference model: position in the instruction cycle
  // (0 idle, 1..4 = F,D,E,C, 5 grant) and wait cycles so far.
  int m_ph;
  int m_wait;
  bit m_to;

  function automatic logic [10:0] model_out();
    logic       ls, req, we, ild;
    logic [3:0] ph;
    ls  = (GROUPX == 2'b01);
    ph  = (m_ph >= 1 && m_ph <= 4) ? 4'(1 << (m_ph - 1)) : 4'b0;
    req = (m_ph == 1) || (m_ph == 3 && ls);
    we  = (m_ph == 3) && ls && STX;
    ild = (m_ph == 1) && MEM_READY;
    return {ph, req, we, ild, 1'(m_ph == 4),
            1'(m_ph == 5), 1'(m_ph == 0), m_to};
  endfunction

  task automatic model_step();
    bit req, abort;
    int nxt;
    abort = 0;
    req = (m_ph == 1) || (m_ph == 3 && GROUPX == 2'b01);
    nxt = m_ph;
    case (m_ph)
      0: nxt = BUS_REQ ? 5 : ((RUN && !m_to) ? 1 : 0);
      2: nxt = 3;
      4: nxt = BUS_REQ ? 5 : ((RUN && !m_to) ? 1 : 0);
      5: nxt = BUS_REQ ? 5 : 0;
      default: begin
        if (!req || MEM_READY) nxt = m_ph + 1;
        else if (WM != 0 && m_wait >= WM) begin
          nxt = 0;
          abort = 1;
        end
      end
    endcase
    if (nxt != m_ph) m_wait = 0;
    else if (req && !MEM_READY) m_wait++;
    if (abort) m_to = 1;
    else if (ERR_CLR) m_to = 0;
    m_ph = nxt;
  endtask

  vec_t tbl[24];

  initial begin
    int fc, ild, pcs, burst;

    tbl[0]  = mk(1,3,0,1,0,0, 4'h0,0,0,0,0,0,1,0);
    tbl[1]  = mk(1,3,0,1,0,0, 4'h1,1,0,1,0,0,0,0);
    tbl[2]  = mk(1,3,0,1,0,0, 4'h2,0,0,0,0,0,0,0);
    tbl[3]  = mk(1,3,0,1,0,0, 4'h4,0,0,0,0,0,0,0);
    tbl[4]  = mk(1,3,0,1,0,0, 4'h8,0,0,0,1,0,0,0);
    tbl[5]  = mk(1,3,0,1,0,0, 4'h1,1,0,1,0,0,0,0);
    tbl[6]  = mk(1,1,0,1,0,0, 4'h2,0,0,0,0,0,0,0);
    tbl[7]  = mk(1,1,0,0,0,0, 4'h4,1,0,0,0,0,0,0);
    tbl[8]  = mk(1,1,0,0,0,0, 4'h4,1,0,0,0,0,0,0);
    tbl[9]  = mk(1,1,0,0,0,0, 4'h4,1,0,0,0,0,0,0);
    tbl[10] = mk(1,1,0,1,0,0, 4'h4,1,0,0,0,0,0,0);
    tbl[11] = mk(1,1,0,1,0,0, 4'h8,0,0,0,1,0,0,0);
    tbl[12] = mk(1,1,1,1,0,0, 4'h1,1,0,1,0,0,0,0);
    tbl[13] = mk(1,1,1,1,0,0, 4'h2,0,0,0,0,0,0,0);
    tbl[14] = mk(1,1,1,0,0,0, 4'h4,1,1,0,0,0,0,0);
    tbl[15] = mk(1,1,1,0,0,0, 4'h4,1,1,0,0,0,0,0);
    tbl[16] = mk(1,1,1,0,0,0, 4'h4,1,1,0,0,0,0,0);
    tbl[17] = mk(1,1,1,1,0,0, 4'h4,1,1,0,0,0,0,0);
    tbl[18] = mk(0,1,1,1,0,0, 4'h8,0,0,0,1,0,0,0);
    tbl[19] = mk(0,1,1,1,0,0, 4'h0,0,0,0,0,0,1,0);
    tbl[20] = mk(0,3,0,1,1,0, 4'h0,0,0,0,0,0,1,0);
    tbl[21] = mk(0,3,0,1,1,0, 4'h0,0,0,0,0,1,0,0);
    tbl[22] = mk(0,3,0,1,0,0, 4'h0,0,0,0,0,1,0,0);
    tbl[23] = mk(0,3,0,1,0,0, 4'h0,0,0,0,0,0,1,0);

    #2;
    chk("reset_outs", 32'(outs()), 32'h002);
    do_reset();

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].run, tbl[i].grp, tbl[i].stx,
            tbl[i].rdy, tbl[i].breq, tbl[i].eclr);
      @(negedge CLK);
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({tbl[i].ph, tbl[i].req, tbl[i].we,
               tbl[i].ild, tbl[i].pci, tbl[i].gnt,
               tbl[i].hlt, tbl[i].to}));
      go_edge();
    end

    // fetch stuck: 15 wait cycles allowed, next low cycle aborts
    do_reset();
    drive(1, 2'b11, 0, 0, 0, 0);
    fc = 0;
    ild = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (PHASEX == 4'b0001) fc++;
      if (INSTR_LD) ild++;
      if (fc > 0 && HALTED) break;
      go_edge();
    end
    chk("to_fetch_len", 32'(fc), 32'(WM + 1));
    chk("to_no_ild", 32'(ild), 32'd0);
    chk("to_flag", 32'(TIMEOUT), 32'd1);
    chk("to_halted", 32'(HALTED), 32'd1);
    go_edge();
    MEM_READY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      go_edge();
      chk("to_blocks_fetch", 32'({HALTED, PHASEX}), 32'h10);
    end
    ERR_CLR = 1'b1;
    go_edge();
    ERR_CLR = 1'b0;
    chk("to_cleared", 32'(TIMEOUT), 32'd0);
    go_edge();
    chk("to_resume", 32'(PHASEX), 32'h1);

    // ready arrives on the expiry cycle
    do_reset();
    drive(1, 2'b11, 0, 0, 0, 0);
    go_edge();
    for (int c = 0; c < WM; c++) go_edge();
    chk("exp_still_fetch", 32'(PHASEX), 32'h1);
    MEM_READY = 1'b1;
    #1;
    chk("exp_ild", 32'(INSTR_LD), 32'd1);
    go_edge();
    chk("exp_decode", 32'({TIMEOUT, PHASEX}), 32'h02);

    // bus request raised mid-instruction
    do_reset();
    drive(1, 2'b11, 0, 1, 0, 0);
    go_edge();
    go_edge();
    chk("bus_decode", 32'(PHASEX), 32'h2);
    BUS_REQ = 1'b1;
    #1;
    chk("bus_no_gnt_d", 32'(BUS_GNT), 32'd0);
    go_edge();
    chk("bus_no_gnt_e", 32'({BUS_GNT, PHASEX}), 32'h04);
    go_edge();
    chk("bus_no_gnt_c", 32'({BUS_GNT, PC_INC, PHASEX}), 32'h18);
    go_edge();
    chk("bus_gnt", 32'({BUS_GNT, PHASEX}), 32'h10);
    go_edge();
    chk("bus_gnt_hold", 32'({BUS_GNT, PHASEX}), 32'h10);
    BUS_REQ = 1'b0;
    go_edge();
    chk("bus_release", 32'({BUS_GNT, HALTED}), 32'h1);
    go_edge();
    chk("bus_resume", 32'(PHASEX), 32'h1);

    // RUN dropped during fetch
    do_reset();
    drive(1, 2'b11, 0, 0, 0, 0);
    go_edge();
    RUN = 1'b0;
    pcs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      pcs += int'(PC_INC);
      if (HALTED) break;
      go_edge();
      MEM_READY = 1'b1;
    end
    chk("rundrop_pcinc", 32'(pcs), 32'd1);
    chk("rundrop_halt", 32'(HALTED), 32'd1);

    // asynchronous reset during an execute wait
    do_reset();
    drive(1, 2'b01, 1, 1, 0, 0);
    go_edge();
    go_edge();
    MEM_READY = 1'b0;
    go_edge();
    go_edge();
    chk("rst_pre_req", 32'({MEM_REQ, MEM_WE, PHASEX}), 32'h34);
    #2;
    RESETN = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 32'h002);
    go_edge();
    chk("rst_held", 32'(outs()), 32'h002);
    RESETN = 1'b1;
    RUN = 1'b0;
    go_edge();
    chk("rst_idle", 32'(outs()), 32'h002);

    // randomized run against the reference model
    do_reset();
    m_ph = 0;
    m_wait = 0;
    m_to = 0;
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (burst > 0) begin
        MEM_READY = 1'b0;
        burst--;
      end else begin
        MEM_READY = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 30) == 0)
          burst = $urandom_range(10, 20);
      end
      RUN = ($urandom_range(0, 9) != 0);
      GROUPX = 2'($urandom);
      STX = 1'($urandom);
      if ($urandom_range(0, 14) == 0) BUS_REQ = ~BUS_REQ;
      ERR_CLR = ($urandom_range(0, 24) == 0);
      @(negedge CLK);
      chk($sformatf("rand%0d", c), 32'(outs()),
          32'(model_out()));
      @(posedge CLK);
      model_step();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
